// File: rtl/uart_tx_fifo_pkg.sv
// Shared types and constants for the FIFO-buffered UART transmitter.
// Also holds the status word layout used by the CPU load-value mux.
package uart_tx_fifo_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_tx_state_t;

   localparam int UART_DATA_BITS = 8;

   localparam int STAT_FULL      = 0;
   localparam int STAT_BUSY      = 1;
   localparam int STAT_OVF       = 2;
   localparam int STAT_COUNT_LSB = 8;

   localparam logic ENABLE  = 1'b1;
   localparam logic DISABLE = 1'b0;

   function automatic logic [31:0] pack_status(input logic [7:0] count,
                                               input logic       ovf,
                                               input logic       busy,
                                               input logic       full);
      logic [31:0] s;
      s                       = '0;
      s[STAT_FULL]            = full;
      s[STAT_BUSY]            = busy;
      s[STAT_OVF]             = ovf;
      s[STAT_COUNT_LSB +: 8]  = count;
      return s;
   endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic [WIDTH-1:0]         i_data,
   output logic [WIDTH-1:0]         o_data,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign w_pop  = i_pop && !o_empty;
   assign w_push = i_push && (!o_full || w_pop);

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

   // DEPTH is a power of two, so pointer overflow is the modulo wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_data  = r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule

// File: rtl/uart_tx_fifo.sv
// Memory-mapped 8N1 UART transmitter fed by a store-strobe FIFO.
// Frames go out back to back while the FIFO holds data; TXD comes straight from a flop.
module uart_tx_fifo
   import uart_tx_fifo_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          tx_we,
   input  logic [7:0]                    tx_data,
   input  logic                          clr_ovf,
   output logic                          uart_txd,
   output logic                          tx_full,
   output logic                          tx_busy,
   output logic                          tx_overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic [31:0]                   status_value
);

   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam int IW = $clog2(UART_DATA_BITS);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   uart_tx_state_t              r_state;
   logic [BW-1:0]               r_baud;
   logic [IW-1:0]               r_bit_idx;
   logic [UART_DATA_BITS-1:0]   r_shift;
   logic                        r_txd;
   logic                        r_ovf;

   logic                        w_empty;
   logic                        w_full;
   logic                        w_pop;
   logic                        w_tc;
   logic                        w_drop;
   logic [UART_DATA_BITS-1:0]   w_head;
   logic [CW-1:0]               w_count;

   assign w_tc   = (r_baud == BW'(CLKS_PER_BIT - 1));
   assign w_pop  = !w_empty && ((r_state == IDLE) || ((r_state == STOP) && w_tc));
   assign w_drop = tx_we && w_full && !w_pop;

   sync_fifo #(
      .WIDTH (UART_DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (tx_we),
      .i_pop   (w_pop),
      .i_data  (tx_data),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_baud    <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_txd     <= 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_pop) begin
                  r_shift <= w_head;
                  r_txd   <= 1'b0;
                  r_baud  <= '0;
                  r_state <= START;
               end
            end
            START: begin
               if (w_tc) begin
                  r_baud    <= '0;
                  r_txd     <= r_shift[0];
                  r_shift   <= {1'b0, r_shift[UART_DATA_BITS-1:1]};
                  r_bit_idx <= '0;
                  r_state   <= DATA;
               end else begin
                  r_baud <= r_baud + BW'(1);
               end
            end
            DATA: begin
               if (w_tc) begin
                  r_baud <= '0;
                  if (r_bit_idx == IW'(UART_DATA_BITS - 1)) begin
                     r_txd   <= 1'b1;
                     r_state <= STOP;
                  end else begin
                     r_txd     <= r_shift[0];
                     r_shift   <= {1'b0, r_shift[UART_DATA_BITS-1:1]};
                     r_bit_idx <= r_bit_idx + IW'(1);
                  end
               end else begin
                  r_baud <= r_baud + BW'(1);
               end
            end
            STOP: begin
               if (w_tc) begin
                  r_baud <= '0;
                  // Chain straight into the next start bit so there is no idle gap.
                  if (w_pop) begin
                     r_shift <= w_head;
                     r_txd   <= 1'b0;
                     r_state <= START;
                  end else begin
                     r_state <= IDLE;
                  end
               end else begin
                  r_baud <= r_baud + BW'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // A dropped write on the same edge as a clear keeps the flag set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ovf <= DISABLE;
      end else if (w_drop) begin
         r_ovf <= ENABLE;
      end else if (clr_ovf) begin
         r_ovf <= DISABLE;
      end
   end

   assign uart_txd     = r_txd;
   assign tx_full      = w_full;
   assign tx_busy      = !w_empty || (r_state != IDLE);
   assign tx_overflow  = r_ovf;
   assign fifo_count   = w_count;
   assign status_value = pack_status(8'(w_count), r_ovf, tx_busy, w_full);

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Memory-mapped serial UART transmitter peripheral; the responder to the CPU core's store/load path at the TX and status addresses. It accepts bytes from single-cycle CPU store strobes into a small FIFO and serialises them as 8N1 frames, LSB first, on a registered TXD pin. It exports a packed status word for the CPU's load-value mux, so software can poll for space and completion.

Parameters:
CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200); legal range >= 2
FIFO_DEPTH, 16, TX FIFO entries; power of two; legal range 2..128

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
tx_we  input  1  single-cycle store strobe; byte written when high at a rising edge
tx_data  input  8  byte to enqueue
clr_ovf  input  1  single-cycle pulse; clears the sticky overflow flag
uart_txd  output  1  serial output; idles high
tx_full  output  1  FIFO full
tx_busy  output  1  high when the FIFO is non-empty or the FSM is not in IDLE
tx_overflow  output  1  sticky flag; set when a write is dropped
fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
status_value  output  32  {16'd0, 8-bit zero-extended fifo_count, 5'd0, tx_overflow, tx_busy, tx_full}

Behaviour:
- Reset (async, while rst=1):
  - uart_txd=1; FIFO emptied (fifo_count=0).
  - tx_full=0, tx_busy=0, tx_overflow=0.
  - FSM=IDLE; baud counter and bit index = 0.
- FSM states: IDLE, START, DATA, STOP.
- Write path:
  - tx_we=1 with FIFO not full: tx_data is pushed at that edge.
  - tx_we=1 with FIFO full and no pop at the same edge: byte dropped, tx_overflow set to 1.
  - Full with a pop at the same edge: write accepted, count unchanged, no overflow.
- IDLE, fifo_count>0 at an edge:
  - Pop the head into the shift register.
  - uart_txd<=0; go to START.
  - Latency: write accepted at edge E0 -> start bit driven from edge E1.
- Bit timing: every bit (start, 8 data, stop) lasts exactly CLKS_PER_BIT cycles.
  - Baud counter counts 0..CLKS_PER_BIT-1; the state/bit advances on terminal count.
  - Frame length = 10*CLKS_PER_BIT cycles.
- START, terminal count: uart_txd<=data[0]; go to DATA with bit index 0.
- DATA:
  - Shift LSB first.
  - After bit 7's terminal count: uart_txd<=1; go to STOP.
- STOP, terminal count:
  - fifo_count>0: pop, uart_txd<=0, go to START. No idle gap between frames.
  - Otherwise: go to IDLE, uart_txd stays 1.
- uart_txd is driven directly from a flop only (glitch-free).
- tx_overflow:
  - Set by a dropped write.
  - Cleared by clr_ovf.
  - Same-edge set and clear: set wins.
- Empty FIFO: no pop is issued; a write to an empty FIFO while in IDLE starts a frame the next cycle.
- Pointers: wrap modulo FIFO_DEPTH; fifo_count distinguishes full from empty.
- rst asserted mid-frame: uart_txd returns to 1 immediately; all queued bytes are discarded.
- The status outputs are combinational from registered state. The CPU samples them in its write-back stage one cycle after the load address.

Decomposition:
- Shared package:
  - uart_tx_state_t enum (IDLE/START/DATA/STOP).
  - UART_DATA_BITS=8.
  - Status bit positions: STAT_FULL=0, STAT_BUSY=1, STAT_OVF=2, STAT_COUNT_LSB=8.
  - Existing ENABLE/DISABLE constants.
- One sub-module, sync_fifo: parameterised width/depth, push/pop, full/empty/count, asynchronous active-high reset.
- FSM, baud counter and shifter stay in uart_tx_fifo.

Test Plan:
(all with CLKS_PER_BIT=4, FIFO_DEPTH=4)
- Reset:
  - Stimulus: assert rst, then release.
  - Required: uart_txd=1, fifo_count=0, tx_busy=0, tx_full=0, status_value=32'h0.
- Single byte:
  - Stimulus: write 8'h55 at E0.
  - Required: uart_txd low for cycles E1..E1+3; then 1,0,1,0,1,0,1,0 each for 4 cycles; stop bit high for 4 cycles.
  - Required: tx_busy falls at E1+40.
- Back-to-back:
  - Stimulus: write 8'h41, 8'h42, 8'h43 on consecutive cycles.
  - Required: three contiguous frames totalling 120 cycles; each next start bit immediately follows the previous stop bit.
- Overflow:
  - Stimulus: write 6 bytes 8'h01..8'h06 on consecutive cycles.
  - Required: 8'h06 dropped; tx_overflow=1, tx_full=1, fifo_count=4, status_value=32'h00000407.
  - Required: 8'h01..8'h05 transmitted in order; clr_ovf pulse then clears bit 2.
- Full with simultaneous pop:
  - Stimulus: with the FIFO full, write 8'hAA at a STOP terminal-count edge.
  - Required: write accepted, fifo_count stays 4, tx_overflow stays 0, 8'hAA transmitted last.
- Reset mid-frame:
  - Stimulus: assert rst during data bit 3 of 8'h00.
  - Required: uart_txd=1 immediately and fifo_count=0.
  - Required: after release, writing 8'hF0 produces one correct frame.
